// File: rtl/fetch_control.sv
// Program counter and fetch sequencer feeding a synchronous-read instruction memory.
// Tags each returned word valid/bubble, replays on stall, redirects on branch, halts on zero word or misaligned target.
module fetch_control #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_stall,
   input  logic        i_branch,
   input  logic [31:0] i_branchPC,
   input  logic [31:0] i_branchOffset,
   input  logic [31:0] i_instruction,
   output logic [31:0] o_PC,
   output logic [31:0] o_PCPlus4,
   output logic [31:0] o_fetchPC,
   output logic        o_fetchValid,
   output logic        o_halted,
   output logic        o_misaligned
);

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_stateNxt;
   logic [31:0] r_pc;
   logic [31:0] r_fetchPC;
   logic        r_fetchValid;
   logic        r_misaligned;

   logic [31:0] w_pcNxt;
   logic [31:0] w_fetchPCNxt;
   logic        w_fetchValidNxt;
   logic        w_misalignedNxt;
   logic [31:0] w_pcPlus4;
   logic [31:0] w_target;
   logic [31:0] w_replayPC;
   logic        w_zeroInstr;

   assign w_pcPlus4   = r_pc + 32'd4;
   assign w_target    = i_branchPC + i_branchOffset;
   assign w_zeroInstr = r_fetchValid && (i_instruction == '0);
   // Replay the word decode refused; if the slot was already a bubble, PC is the address to retry.
   assign w_replayPC  = r_fetchValid ? r_fetchPC : r_pc;

   always_comb begin
      w_stateNxt      = r_state;
      w_pcNxt         = r_pc;
      w_fetchPCNxt    = r_fetchPC;
      w_fetchValidNxt = 1'b0;
      w_misalignedNxt = r_misaligned;
      case (r_state)
         S_BOOT: begin
            w_stateNxt   = S_RUN;
            w_fetchPCNxt = r_pc;
            if (i_stall) begin
               w_pcNxt = w_replayPC;
            end else begin
               w_pcNxt         = w_pcPlus4;
               w_fetchValidNxt = 1'b1;
            end
         end
         S_RUN: begin
            w_fetchPCNxt = r_pc;
            if (i_branch && (w_target[1:0] != 2'b00)) begin
               w_stateNxt      = S_HALT;
               w_misalignedNxt = 1'b1;
            end else if (i_branch) begin
               w_pcNxt = w_target;
            end else if (w_zeroInstr) begin
               w_stateNxt = S_HALT;
            end else if (i_stall) begin
               w_pcNxt = w_replayPC;
            end else begin
               w_pcNxt         = w_pcPlus4;
               w_fetchValidNxt = 1'b1;
            end
         end
         S_HALT: begin
            w_stateNxt = S_HALT;
         end
         default: begin
            w_stateNxt = S_HALT;
         end
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_state      <= S_BOOT;
         r_pc         <= RESET_PC;
         r_fetchPC    <= RESET_PC;
         r_fetchValid <= 1'b0;
         r_misaligned <= 1'b0;
      end else begin
         r_state      <= w_stateNxt;
         r_pc         <= w_pcNxt;
         r_fetchPC    <= w_fetchPCNxt;
         r_fetchValid <= w_fetchValidNxt;
         r_misaligned <= w_misalignedNxt;
      end
   end

   assign o_PC         = r_pc;
   assign o_PCPlus4    = w_pcPlus4;
   assign o_fetchPC    = r_fetchPC;
   assign o_fetchValid = r_fetchValid;
   assign o_halted     = (r_state == S_HALT);
   assign o_misaligned = r_misaligned;

endmodule
